// File: rtl/dimmer_pkg.sv
// Shared state types and sizing helpers for the LED dimmer array.
package dimmer_pkg;

    typedef enum logic {IDLE, HELD} key_state_t;
    typedef enum logic {SCAN_UP, SCAN_DOWN} scan_state_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned width_of(input int unsigned n);
        if (n < 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

    // Interval shortened by the test divisor, clamped so it never collapses to zero.
    function automatic int unsigned scaled(input int unsigned cycles, input int unsigned div);
        int unsigned q;
        q = (div == 0) ? cycles : cycles / div;
        return (q == 0) ? 1 : q;
    endfunction

endpackage

// File: rtl/key_repeat.sv
// One key: 2-flop synchroniser, debounce filter, IDLE/HELD FSM and hold-to-repeat,
// producing a single-cycle step pulse on press and on every repeat interval.
module key_repeat
    import dimmer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_CYCLES   = 25000000,
    parameter int unsigned TEST_DIV        = 10
) (
    input  logic clk,
    input  logic clr,
    input  logic key_n,
    input  logic test,
    input  logic restart,
    output logic step
);

    localparam int unsigned DW = width_of(DEBOUNCE_CYCLES);
    localparam int unsigned RW = width_of(REPEAT_CYCLES);
    localparam logic [DW-1:0] DEB_LAST      = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST_SLOW = RW'(REPEAT_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST_FAST = RW'(scaled(REPEAT_CYCLES, TEST_DIV) - 1);

    logic            key_s1;
    logic            key_s2;
    logic            key_db;
    logic [DW-1:0]   deb_cnt;
    logic [RW-1:0]   rep_cnt;
    logic [RW-1:0]   rep_last;
    logic            accept;
    logic            step_q;
    key_state_t      state;

    assign rep_last = test ? REP_LAST_FAST : REP_LAST_SLOW;
    // The filter is about to take the synchronised value on this edge.
    assign accept   = (key_s2 != key_db) && (deb_cnt == DEB_LAST);
    assign step     = step_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            key_s1  <= 1'b1;
            key_s2  <= 1'b1;
            key_db  <= 1'b1;
            deb_cnt <= '0;
            rep_cnt <= '0;
            step_q  <= 1'b0;
            state   <= IDLE;
        end else begin
            key_s1 <= key_n;
            key_s2 <= key_s1;
            step_q <= 1'b0;

            if (key_s2 == key_db) begin
                deb_cnt <= '0;
            end else if (accept) begin
                key_db  <= key_s2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end

            // Transitions follow the accept event so the press pulse lands with the
            // debounced state change rather than a cycle later.
            case (state)
                IDLE: begin
                    rep_cnt <= '0;
                    if (accept && !key_s2) begin
                        state  <= HELD;
                        step_q <= 1'b1;
                    end
                end
                HELD: begin
                    if (accept && key_s2) begin
                        state   <= IDLE;
                        rep_cnt <= '0;
                    end else if (restart) begin
                        rep_cnt <= '0;
                    end else if (rep_cnt >= rep_last) begin
                        rep_cnt <= '0;
                        step_q  <= 1'b1;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/led_dimmer_array.sv
// Multi-channel PWM LED dimmer: key-driven brightness level, uniform or Kitt scanner
// output, with a test mode that shortens the PWM, repeat and scan intervals.
module led_dimmer_array
    import dimmer_pkg::*;
#(
    parameter int unsigned NUM_LEDS        = 10,
    parameter int unsigned STEPS           = 16,
    parameter int unsigned PWM_PERIOD      = 250000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_CYCLES   = 25000000,
    parameter int unsigned SCAN_CYCLES     = 5000000,
    parameter int unsigned TEST_DIV        = 10
) (
    input  logic                      clock_50,
    input  logic                      clr,
    input  logic                      up_n,
    input  logic                      down_n,
    input  logic                      test,
    input  logic                      mode,
    output logic [NUM_LEDS-1:0]       leds,
    output logic [$clog2(STEPS)-1:0]  level
);

    localparam int unsigned LW     = width_of(STEPS);
    localparam int unsigned PW     = width_of(PWM_PERIOD + 1);
    localparam int unsigned SW     = width_of(SCAN_CYCLES);
    localparam int unsigned AW     = width_of(NUM_LEDS);
    localparam int unsigned TW     = LW + PW;
    localparam int unsigned P_FAST = scaled(PWM_PERIOD, TEST_DIV);
    localparam int unsigned S_FAST = scaled(SCAN_CYCLES, TEST_DIV);

    localparam logic [LW-1:0] LEVEL_MAX = LW'(STEPS - 1);
    localparam logic [TW-1:0] DIVISOR   = TW'(STEPS - 1);
    localparam logic [AW-1:0] POS_TURN  = AW'(NUM_LEDS - 2);

    logic            test_s1, test_s2, test_q;
    logic            mode_s1, mode_s2, mode_q;
    logic            test_edge, mode_edge;
    logic            up_step, down_step;
    logic [LW-1:0]   level_q;
    logic [PW-1:0]   pwm_cnt;
    logic [PW-1:0]   pwm_last;
    logic [TW-1:0]   frame_len;
    logic [TW-1:0]   thr_full, thr_half;
    logic            pwm_full, pwm_half;
    logic [SW-1:0]   scan_cnt;
    logic [SW-1:0]   scan_last;
    logic [AW-1:0]   pos_q;
    scan_state_t     dir_q;

    assign test_edge = test_s2 ^ test_q;
    assign mode_edge = mode_s2 ^ mode_q;
    assign level     = level_q;

    key_repeat #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .TEST_DIV        (TEST_DIV)
    ) u_key_up (
        .clk     (clock_50),
        .clr     (clr),
        .key_n   (up_n),
        .test    (test_s2),
        .restart (test_edge),
        .step    (up_step)
    );

    key_repeat #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .TEST_DIV        (TEST_DIV)
    ) u_key_down (
        .clk     (clock_50),
        .clr     (clr),
        .key_n   (down_n),
        .test    (test_s2),
        .restart (test_edge),
        .step    (down_step)
    );

    always_comb begin
        frame_len = test_s2 ? TW'(P_FAST) : TW'(PWM_PERIOD);
        pwm_last  = test_s2 ? PW'(P_FAST - 1) : PW'(PWM_PERIOD - 1);
        scan_last = test_s2 ? SW'(S_FAST - 1) : SW'(SCAN_CYCLES - 1);
        // Full-width product before the divide keeps the top level exactly at 100%.
        thr_full  = (TW'(level_q) * frame_len) / DIVISOR;
        thr_half  = (TW'(level_q >> 1) * frame_len) / DIVISOR;
        pwm_full  = TW'(pwm_cnt) < thr_full;
        pwm_half  = TW'(pwm_cnt) < thr_half;
    end

    always_ff @(posedge clock_50) begin
        if (clr) begin
            test_s1 <= 1'b0;
            test_s2 <= 1'b0;
            test_q  <= 1'b0;
            mode_s1 <= 1'b0;
            mode_s2 <= 1'b0;
            mode_q  <= 1'b0;
            level_q <= '0;
            pwm_cnt <= '0;
        end else begin
            test_s1 <= test;
            test_s2 <= test_s1;
            test_q  <= test_s2;
            mode_s1 <= mode;
            mode_s2 <= mode_s1;
            mode_q  <= mode_s2;

            if (up_step && !down_step && level_q != LEVEL_MAX) begin
                level_q <= level_q + 1'b1;
            end else if (down_step && !up_step && level_q != '0) begin
                level_q <= level_q - 1'b1;
            end

            // >= rather than == so a shortened period never lets the frame run on.
            if (test_edge || pwm_cnt >= pwm_last) begin
                pwm_cnt <= '0;
            end else begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_50) begin
        if (clr) begin
            pos_q    <= '0;
            dir_q    <= SCAN_UP;
            scan_cnt <= '0;
        end else if (mode_edge) begin
            pos_q    <= '0;
            dir_q    <= SCAN_UP;
            scan_cnt <= '0;
        end else if (test_edge) begin
            scan_cnt <= '0;
        end else if (mode_s2) begin
            if (scan_cnt >= scan_last) begin
                scan_cnt <= '0;
                case (dir_q)
                    SCAN_UP: begin
                        pos_q <= pos_q + 1'b1;
                        if (pos_q == POS_TURN) begin
                            dir_q <= SCAN_DOWN;
                        end
                    end
                    SCAN_DOWN: begin
                        pos_q <= pos_q - 1'b1;
                        if (pos_q == AW'(1)) begin
                            dir_q <= SCAN_UP;
                        end
                    end
                endcase
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        leds = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (!mode_s2) begin
                leds[i] = pwm_full;
            end else if (i == int'(pos_q)) begin
                leds[i] = pwm_full;
            end else if (i == int'(pos_q) + 1 || i == int'(pos_q) - 1) begin
                leds[i] = pwm_half;
            end
        end
    end

endmodule

// File: tb/tb_led_dimmer_array.sv
// Directed bench for led_dimmer_array with a queue of expected values per check point.
module tb_led_dimmer_array;

    localparam int NL = 4;
    localparam int ST = 5;

    logic          clock_50 = 1'b0;
    logic          clr;
    logic          up_n;
    logic          down_n;
    logic          test;
    logic          mode;
    logic [NL-1:0] leds;
    logic [2:0]    level;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    led_dimmer_array #(
        .NUM_LEDS        (NL),
        .STEPS           (ST),
        .PWM_PERIOD      (100),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (50),
        .SCAN_CYCLES     (20),
        .TEST_DIV        (10)
    ) dut (
        .clock_50 (clock_50),
        .clr      (clr),
        .up_n     (up_n),
        .down_n   (down_n),
        .test     (test),
        .mode     (mode),
        .leds     (leds),
        .level    (level)
    );

    always #5 clock_50 = ~clock_50;

    task automatic expect_v(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic compare(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: got %0d required a queued value", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s: got %0d required %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock_50);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        int   cnt;
        int   cnt2;
        int   bad;
        int   rises;
        int   p;
        int   nb;
        logic prev;

        clr = 1'b1; up_n = 1'b1; down_n = 1'b1; test = 1'b0; mode = 1'b0;
        tick(3);
        clr = 1'b0;
        expect_v("reset_level", 0); compare(32'(level));
        expect_v("reset_leds", 0);  compare(32'(leds));

        // Single 10-cycle press: level 1 seven cycles after the fall.
        up_n = 1'b0;
        expect_v("press_before", 0); tick(6); compare(32'(level));
        expect_v("press_latency", 1); tick(1); compare(32'(level));
        tick(3); up_n = 1'b1; tick(20);
        cnt = 0; cnt2 = 0;
        for (int i = 0; i < 100; i++) begin
            if (leds == 4'hf) cnt++;
            else if (leds != 4'h0) cnt2++;
            tick(1);
        end
        expect_v("duty_level1", 25); compare(32'(cnt));
        expect_v("leds_uniform", 0); compare(32'(cnt2));

        // Short glitch is filtered.
        up_n = 1'b0; tick(3); up_n = 1'b1; tick(20);
        expect_v("glitch_ignored", 1); compare(32'(level));

        // Hold: step on press, then every 50 cycles, saturating at 4.
        up_n = 1'b0; cnt = 0;
        for (int t = 1; t <= 200; t++) begin
            tick(1);
            if (t == 6 || t == 56 || t == 106) begin
                expect_v("hold_pre", t / 50 + 1); compare(32'(level));
            end
            if (t == 7 || t == 57 || t == 107) begin
                expect_v("hold_step", t / 50 + 2); compare(32'(level));
            end
            if (t > 107 && leds == 4'hf) cnt++;
        end
        expect_v("hold_saturate", 4); compare(32'(level));
        expect_v("hold_leds_on", 93); compare(32'(cnt));
        up_n = 1'b1; tick(20);

        // Both keys: coincident pulses cancel.
        up_n = 1'b0; down_n = 1'b0; cnt = 0; cnt2 = 0;
        for (int t = 1; t <= 120; t++) begin
            tick(1);
            if (level != 3'd4) cnt++;
            if (leds == 4'hf) cnt2++;
        end
        expect_v("both_cancel", 0); compare(32'(cnt));
        expect_v("both_leds_on", 120); compare(32'(cnt2));
        up_n = 1'b1; down_n = 1'b1; tick(20);
        expect_v("both_release", 4); compare(32'(level));

        // Down hold to 0.
        down_n = 1'b0; cnt = 0;
        for (int t = 1; t <= 250; t++) begin
            tick(1);
            if (t == 7)   begin expect_v("down_step1", 3); compare(32'(level)); end
            if (t == 57)  begin expect_v("down_step2", 2); compare(32'(level)); end
            if (t > 157 && leds != 4'h0) cnt++;
        end
        expect_v("down_floor", 0); compare(32'(level));
        expect_v("down_leds_off", 0); compare(32'(cnt));
        down_n = 1'b1; tick(20);

        up_n = 1'b0; tick(160); up_n = 1'b1; tick(20);
        expect_v("back_to_max", 4); compare(32'(level));

        // Kitt scanner: positions 0,1,2,3,2,1,0 at 20-cycle steps.
        mode = 1'b1; tick(3);
        cnt2 = 0; bad = 0;
        for (int k = 0; k < 7; k++) begin
            p  = (k <= 3) ? k : 6 - k;
            nb = (p == 0) ? 1 : p - 1;
            cnt = 0;
            for (int j = 0; j < 20; j++) begin
                if (leds[p]) cnt++;
                if (k < 5 && leds[nb]) cnt2++;
                for (int i = 0; i < NL; i++) begin
                    if (i != p && i != p - 1 && i != p + 1 && leds[i]) bad++;
                end
                tick(1);
            end
            expect_v("kitt_pos_lit", 20); compare(32'(cnt));
        end
        expect_v("kitt_neighbour_duty", 50); compare(32'(cnt2));
        expect_v("kitt_far_dark", 0); compare(32'(bad));
        mode = 1'b0; tick(5);

        // Two single presses down to level 2.
        down_n = 1'b0; tick(10); down_n = 1'b1; tick(20);
        down_n = 1'b0; tick(10); down_n = 1'b1; tick(20);
        expect_v("level_two", 2); compare(32'(level));

        // Test mode: 10-cycle frame, 5 high.
        test = 1'b1; tick(5);
        rises = 0; cnt = 0; prev = leds[0];
        for (int i = 0; i <= 50; i++) begin
            if (i < 50 && leds[0]) cnt++;
            if (i > 0 && leds[0] && !prev) rises++;
            prev = leds[0];
            tick(1);
        end
        expect_v("test_frames", 5); compare(32'(rises));
        expect_v("test_duty", 25); compare(32'(cnt));

        // Mid-frame clear.
        tick(3);
        clr = 1'b1; tick(1); clr = 1'b0;
        expect_v("clr_level", 0); compare(32'(level));
        expect_v("clr_leds", 0);  compare(32'(leds));
        tick(12);
        expect_v("clr_stays_dark", 0); compare(32'(leds));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
